// File: rtl/ysyx_24100027_ctrl_seq.sv
// ysyx_24100027_ctrl_seq: multi-cycle control sequencer for the RV32I core.
// Accepts one instruction per FETCH handshake and walks it through
// DECODE -> EXEC -> (MEM) -> WB, halting on ebreak or an illegal opcode.
module ysyx_24100027_ctrl_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [2:0]  extop,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_wen,
  input  logic        mem_ack,
  output logic        reg_wen,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        halt,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_LUI    = 4'd0,
    C_AUIPC  = 4'd1,
    C_JAL    = 4'd2,
    C_JALR   = 4'd3,
    C_BRANCH = 4'd4,
    C_LOAD   = 4'd5,
    C_STORE  = 4'd6,
    C_OPIMM  = 4'd7,
    C_OP     = 4'd8,
    C_SYS    = 4'd9
  } cls_t;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t      state;
  cls_t        cls;
  logic [31:0] ir;
  logic        wflag;

  cls_t        dec_cls;
  logic [2:0]  dec_ext;
  logic        dec_mwen;
  logic        dec_ok;
  logic        dec_wflag;

  // Combinational opcode decode of the latched instruction word.
  always_comb begin
    dec_cls  = C_OP;
    dec_ext  = EXT_I;
    dec_mwen = 1'b0;
    dec_ok   = 1'b1;
    case (ir[6:0])
      7'b0110111: begin dec_cls = C_LUI;    dec_ext = EXT_U; end
      7'b0010111: begin dec_cls = C_AUIPC;  dec_ext = EXT_U; end
      7'b1101111: begin dec_cls = C_JAL;    dec_ext = EXT_J; end
      7'b1100111: begin dec_cls = C_JALR;   dec_ext = EXT_I; end
      7'b1100011: begin dec_cls = C_BRANCH; dec_ext = EXT_B; end
      7'b0000011: begin dec_cls = C_LOAD;   dec_ext = EXT_I; end
      7'b0100011: begin dec_cls = C_STORE;  dec_ext = EXT_S; dec_mwen = 1'b1; end
      7'b0010011: begin dec_cls = C_OPIMM;  dec_ext = EXT_I; end
      7'b0110011: begin dec_cls = C_OP;     dec_ext = EXT_I; end
      7'b1110011: begin dec_cls = C_SYS;    dec_ok  = (ir == EBREAK); end
      default:    dec_ok = 1'b0;
    endcase
    dec_wflag = (dec_cls != C_BRANCH) && (dec_cls != C_STORE) && (dec_cls != C_SYS);
  end

  // Sequencer: state, decoded registers and registered Moore strobes.
  // Strobes are loaded with the value for the state being entered so they
  // line up with the state register without extra output decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      ir         <= '0;
      cls        <= C_OP;
      wflag      <= 1'b0;
      extop      <= '0;
      pc_sel     <= '0;
      mem_wen    <= 1'b0;
      halt       <= 1'b0;
      illegal    <= 1'b0;
      inst_ready <= 1'b1;
      mem_req    <= 1'b0;
      reg_wen    <= 1'b0;
      pc_wen     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (inst_valid) begin
            ir         <= inst;
            inst_ready <= 1'b0;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_ok) begin
            cls     <= dec_cls;
            extop   <= dec_ext;
            mem_wen <= dec_mwen;
            wflag   <= dec_wflag;
            state   <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            halt    <= 1'b1;
            state   <= S_HALT;
          end
        end
        S_EXEC: begin
          case (cls)
            C_JAL:    pc_sel <= PC_REL;
            C_BRANCH: pc_sel <= br_taken ? PC_REL : PC_SEQ;
            C_JALR:   pc_sel <= PC_JALR;
            default:  pc_sel <= PC_SEQ;
          endcase
          if (cls == C_LOAD || cls == C_STORE) begin
            mem_req <= 1'b1;
            state   <= S_MEM;
          end else if (cls == C_SYS) begin
            halt  <= 1'b1;
            state <= S_HALT;
          end else begin
            pc_wen  <= 1'b1;
            reg_wen <= wflag;
            state   <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            pc_wen  <= 1'b1;
            reg_wen <= wflag;
            state   <= S_WB;
          end
        end
        S_WB: begin
          pc_wen     <= 1'b0;
          reg_wen    <= 1'b0;
          inst_ready <= 1'b1;
          state      <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          inst_ready <= 1'b1;
          mem_req    <= 1'b0;
          reg_wen    <= 1'b0;
          pc_wen     <= 1'b0;
          state      <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100027_ctrl_seq.sv
// Directed scoreboard bench for ysyx_24100027_ctrl_seq.
module tb_ysyx_24100027_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [2:0]  extop;
  logic        br_taken;
  logic        mem_req;
  logic        mem_wen;
  logic        mem_ack;
  logic        reg_wen;
  logic        pc_wen;
  logic [1:0]  pc_sel;
  logic        halt;
  logic        illegal;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic        reg_wen;
    logic [1:0]  pc_sel;
    logic [2:0]  extop;
    logic        mem_wen;
    int unsigned mcyc;
  } exp_t;

  exp_t sb[$];

  ysyx_24100027_ctrl_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .extop      (extop),
    .br_taken   (br_taken),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_ack    (mem_ack),
    .reg_wen    (reg_wen),
    .pc_wen     (pc_wen),
    .pc_sel     (pc_sel),
    .halt       (halt),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic [1:0] ps, input logic [2:0] ex,
                              input logic mw, input int unsigned mc);
    exp_t e;
    e.reg_wen = rw;
    e.pc_sel  = ps;
    e.extop   = ex;
    e.mem_wen = mw;
    e.mcyc    = mc;
    return e;
  endfunction

  // One full instruction; ack_at = MEM cycle (1-based) in which mem_ack pulses.
  task automatic do_inst(input string tag, input logic [31:0] w, input logic br,
                         input int unsigned ack_at, input exp_t e);
    exp_t        got;
    int unsigned c;
    int unsigned mc;
    sb.push_back(e);
    chk({tag, "_rdy_pre"}, inst_ready, 1'b1);
    inst       = w;
    inst_valid = 1'b1;
    br_taken   = br;
    tick();
    inst_valid = 1'b0;
    inst       = $urandom;
    chk({tag, "_rdy_dec"}, inst_ready, 1'b0);
    c  = 1;
    mc = 0;
    while (!pc_wen && c < 20) begin
      if (mem_req) begin
        mc++;
        if (mem_wen !== e.mem_wen) chk({tag, "_mwen_mem"}, mem_wen, e.mem_wen);
        if (inst_ready !== 1'b0) chk({tag, "_rdy_mem"}, inst_ready, 1'b0);
        mem_ack = (mc == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      tick();
      c++;
    end
    mem_ack = 1'b0;
    got = sb.pop_front();
    chk({tag, "_pcwen"},   pc_wen,     1'b1);
    chk({tag, "_regwen"},  reg_wen,    got.reg_wen);
    chk({tag, "_pcsel"},   pc_sel,     got.pc_sel);
    chk({tag, "_extop"},   extop,      got.extop);
    chk({tag, "_mwen"},    mem_wen,    got.mem_wen);
    chk({tag, "_mcyc"},    mc,         got.mcyc);
    chk({tag, "_wbcyc"},   c,          3 + got.mcyc);
    chk({tag, "_rdy_wb"},  inst_ready, 1'b0);
    chk({tag, "_mreq_wb"}, mem_req,    1'b0);
    tick();
    chk({tag, "_rdy_post"},   inst_ready, 1'b1);
    chk({tag, "_pcwen_post"}, pc_wen,     1'b0);
    chk({tag, "_rwen_post"},  reg_wen,    1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    br_taken   = 1'b0;
    mem_ack    = 1'b0;
    tick();
    tick();
    chk("rst_rdy",   inst_ready, 1'b1);
    chk("rst_mreq",  mem_req,    1'b0);
    chk("rst_rwen",  reg_wen,    1'b0);
    chk("rst_pcwen", pc_wen,     1'b0);
    chk("rst_halt",  halt,       1'b0);
    chk("rst_ill",   illegal,    1'b0);
    chk("rst_ext",   extop,      3'b000);
    chk("rst_psel",  pc_sel,     2'b00);
    rst_n = 1'b1;

    do_inst("addi",  32'h0050_0093, 1'b0, 0, mk(1'b1, 2'b00, 3'b000, 1'b0, 0));
    do_inst("beq_t", 32'h0000_0463, 1'b1, 0, mk(1'b0, 2'b01, 3'b011, 1'b0, 0));
    do_inst("beq_n", 32'h0000_0463, 1'b0, 0, mk(1'b0, 2'b00, 3'b011, 1'b0, 0));
    do_inst("lw",    32'h0000_A103, 1'b0, 3, mk(1'b1, 2'b00, 3'b000, 1'b0, 3));
    do_inst("sw",    32'h0020_A023, 1'b0, 1, mk(1'b0, 2'b00, 3'b010, 1'b1, 1));
    do_inst("jal",   32'h0080_00EF, 1'b1, 0, mk(1'b1, 2'b01, 3'b100, 1'b0, 0));
    do_inst("jalr",  32'h0000_80E7, 1'b0, 0, mk(1'b1, 2'b10, 3'b000, 1'b0, 0));
    do_inst("lui",   32'h1234_50B7, 1'b1, 0, mk(1'b1, 2'b00, 3'b001, 1'b0, 0));

    // Reset while a store sits in MEM: abort, then a stray ack must be ignored.
    inst = 32'h0020_A023;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) tick();
    chk("abort_mreq_pre", mem_req, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_mreq", mem_req,    1'b0);
    chk("abort_rdy",  inst_ready, 1'b1);
    chk("abort_ext",  extop,      3'b000);
    chk("abort_mwen", mem_wen,    1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_rdy",   inst_ready, 1'b1);
    chk("stray_pcwen", pc_wen,     1'b0);
    chk("stray_rwen",  reg_wen,    1'b0);
    chk("stray_mreq",  mem_req,    1'b0);

    // ebreak: retires into HALT without illegal, then ignores inst_valid.
    inst = 32'h0010_0073;
    inst_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("ebrk_halt", halt,    1'b1);
    chk("ebrk_ill",  illegal, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (inst_ready !== 1'b0) chk("ebrk_rdy", inst_ready, 1'b0);
      if (pc_wen !== 1'b0) chk("ebrk_pcwen", pc_wen, 1'b0);
      tick();
    end
    chk("ebrk_rdy_end",  inst_ready, 1'b0);
    chk("ebrk_halt_end", halt,       1'b1);
    inst_valid = 1'b0;

    // All-zero word is illegal and halts right after DECODE.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ill_rst_halt", halt, 1'b0);
    inst = 32'h0000_0000;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("ill_dec_halt", halt, 1'b0);
    tick();
    chk("ill_halt", halt,       1'b1);
    chk("ill_ill",  illegal,    1'b1);
    chk("ill_rdy",  inst_ready, 1'b0);
    tick();
    chk("ill_pcwen", pc_wen, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
